// File: rtl/adder_share_arbiter_if.sv
// Request/operand and result handshake bundle between NUM_REQ requesters and the
// shared-adder arbiter.
interface adder_share_arbiter_if #(
    parameter int N       = 32,
    parameter int NUM_REQ = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_i;
    logic [NUM_REQ*N-1:0] a_i;
    logic [NUM_REQ*N-1:0] b_i;
    logic [NUM_REQ-1:0]   gnt_o;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [N-1:0]         res_data_o;
    logic [IDW-1:0]       res_id_o;

    modport master (
        output req_i, a_i, b_i, res_ready_i,
        input  gnt_o, res_valid_o, res_data_o, res_id_o
    );

    modport slave (
        input  req_i, a_i, b_i, res_ready_i,
        output gnt_o, res_valid_o, res_data_o, res_id_o
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// One N-bit adder time-shared by NUM_REQ requesters: round-robin grant, registered
// sum plus winner ID behind a valid/ready result register.
module single_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_y
);
    // Carry-out is intentionally discarded: the sum wraps modulo 2^N.
    assign o_y = i_a + i_b;
endmodule

module adder_share_arbiter #(
    parameter int N       = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_share_arbiter_if.slave  bus
);
    localparam int             IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDW-1:0]       r_rr_ptr;
    logic [N-1:0]         r_sum_p1;
    logic [IDW-1:0]       r_id_p1;
    logic                 w_can_issue;
    logic                 w_issue;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [IDW-1:0]       w_winner;
    logic [N-1:0]         w_opa_p0;
    logic [N-1:0]         w_opb_p0;
    logic [N-1:0]         w_sum_p0;

    // A slot is free when nothing is held or the held result leaves this cycle.
    assign w_can_issue = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.res_ready_i);

    always_comb begin
        int idx;
        w_gnt    = '0;
        w_winner = '0;
        w_issue  = 1'b0;
        idx      = 0;
        if (!rst && w_can_issue) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                idx = int'(r_rr_ptr) + off;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!w_issue && bus.req_i[idx]) begin
                    w_issue    = 1'b1;
                    w_winner   = IDW'(idx);
                    w_gnt[idx] = 1'b1;
                end
            end
        end
    end

    // Stage p0: winner's operands straight from the requester, no capture before grant.
    always_comb begin
        w_opa_p0 = '0;
        w_opb_p0 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_opa_p0 = bus.a_i[k*N +: N];
                w_opb_p0 = bus.b_i[k*N +: N];
            end
        end
    end

    single_adder #(.N(N)) u_adder (
        .i_a (w_opa_p0),
        .i_b (w_opb_p0),
        .o_y (w_sum_p0)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_HOLD;
            S_HOLD:  if (bus.res_ready_i && !w_issue) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
        end
    end

    // Stage p1: registered sum and winner ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_p1 <= '0;
            r_id_p1  <= '0;
        end else if (w_issue) begin
            r_sum_p1 <= w_sum_p0;
            r_id_p1  <= w_winner;
        end
    end

    assign bus.gnt_o       = w_gnt;
    assign bus.res_valid_o = (r_state == S_HOLD);
    assign bus.res_data_o  = r_sum_p1;
    assign bus.res_id_o    = r_id_p1;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed and randomized bench for adder_share_arbiter against a cycle-level
// reference model of the grant/result rules.
module tb_adder_share_arbiter;
    localparam int N  = 32;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    adder_share_arbiter_if #(.N(N), .NUM_REQ(NR)) bus ();

    adder_share_arbiter #(.N(N), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit             m_valid;
    logic [N-1:0]   m_data;
    int             m_id;
    int             m_ptr;
    logic [NR-1:0]  obs_gnt;
    int             last_w;

    // Random requester state
    bit             pend[NR];
    logic [N-1:0]   av[NR];
    logic [N-1:0]   bv[NR];
    int             wait_slots[NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
        for (int k = 0; k < NR; k++) begin
            pend[k]       = 1'b0;
            wait_slots[k] = 0;
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        logic [NR-1:0] eg;
        logic [N-1:0]  sa, sb;
        int            w, idx;
        bit            can;
        sa = '0;
        sb = '0;
        @(negedge clk);
        chk("res_valid", 64'(bus.res_valid_o), 64'(m_valid));
        if (m_valid) begin
            chk("res_data", 64'(bus.res_data_o), 64'(m_data));
            chk("res_id", 64'(bus.res_id_o), 64'(m_id));
        end
        can = !m_valid || (bus.res_ready_i === 1'b1);
        w   = -1;
        eg  = '0;
        if (can) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (w < 0 && bus.req_i[idx]) w = idx;
            end
        end
        if (w >= 0) begin
            eg[w] = 1'b1;
            sa    = bus.a_i[w*N +: N];
            sb    = bus.b_i[w*N +: N];
        end
        obs_gnt = bus.gnt_o;
        chk("gnt", 64'(obs_gnt), 64'(eg));
        last_w = w;
        @(posedge clk);
        if (can) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = sa + sb;
                m_id    = w;
                m_ptr   = (w + 1) % NR;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    // Asserts rst between clock edges and expects every output to clear at once.
    task automatic do_reset();
        #1 rst = 1'b1;
        bus.req_i = '1;
        #1;
        chk("rst_valid", 64'(bus.res_valid_o), 64'(0));
        chk("rst_data", 64'(bus.res_data_o), 64'(0));
        chk("rst_id", 64'(bus.res_id_o), 64'(0));
        chk("rst_gnt", 64'(bus.gnt_o), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_gnt_held", 64'(bus.gnt_o), 64'(0));
        bus.req_i = '0;
        rst       = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NR-1:0] rr_exp[5];
        logic [N-1:0]  hold_data;
        logic [N-1:0]  exp_sum;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        bus.req_i       = '0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.res_ready_i = 1'b0;
        last_w          = -1;
        obs_gnt         = '0;
        model_clear();
        do_reset();

        // Single request and drain
        bus.res_ready_i = 1'b1;
        bus.req_i       = 4'b0001;
        bus.a_i[0 +: N] = 32'hE59F1020;
        bus.b_i[0 +: N] = 32'h4;
        tick();
        chk("single_gnt", 64'(obs_gnt), 64'(4'b0001));
        chk("single_valid", 64'(bus.res_valid_o), 64'(1));
        chk("single_data", 64'(bus.res_data_o), 64'(32'hE59F1024));
        chk("single_id", 64'(bus.res_id_o), 64'(0));
        bus.req_i = '0;
        tick();
        chk("drain_valid", 64'(bus.res_valid_o), 64'(0));
        tick();

        // Arithmetic and wrap-around
        bus.req_i         = 4'b0100;
        bus.a_i[2*N +: N] = 32'h28A44EAF;
        bus.b_i[2*N +: N] = 32'hA895D275;
        tick();
        chk("arith_gnt", 64'(obs_gnt), 64'(4'b0100));
        chk("arith_data", 64'(bus.res_data_o), 64'(32'hD13A2124));
        chk("arith_id", 64'(bus.res_id_o), 64'(2));
        bus.req_i         = 4'b1000;
        bus.a_i[3*N +: N] = 32'hFFFFFFFF;
        bus.b_i[3*N +: N] = 32'h1;
        tick();
        chk("wrap_data", 64'(bus.res_data_o), 64'(32'h0));
        chk("wrap_id", 64'(bus.res_id_o), 64'(3));
        bus.req_i = '0;
        chk("pre_rst_valid", 64'(bus.res_valid_o), 64'(1));
        do_reset();

        // Round-robin with all requesters active
        for (int k = 0; k < NR; k++) begin
            bus.a_i[k*N +: N] = 32'(k * 16);
            bus.b_i[k*N +: N] = 32'(k + 1);
        end
        bus.res_ready_i = 1'b1;
        bus.req_i       = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gnt", 64'(obs_gnt), 64'(rr_exp[i]));
            chk("rr_id", 64'(bus.res_id_o), 64'(i % NR));
        end

        // Backpressure
        bus.req_i = 4'b0110;
        tick();
        chk("bp_first_gnt", 64'(obs_gnt), 64'(4'b0010));
        hold_data       = bus.res_data_o;
        bus.res_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_gnt", 64'(obs_gnt), 64'(0));
            chk("bp_stall_data", 64'(bus.res_data_o), 64'(hold_data));
            chk("bp_stall_id", 64'(bus.res_id_o), 64'(1));
        end
        bus.res_ready_i = 1'b1;
        exp_sum         = bus.a_i[2*N +: N] + bus.b_i[2*N +: N];
        tick();
        chk("bp_release_gnt", 64'(obs_gnt), 64'(4'b0100));
        chk("bp_release_id", 64'(bus.res_id_o), 64'(2));
        chk("bp_release_data", 64'(bus.res_data_o), 64'(exp_sum));
        bus.req_i = '0;
        tick();
        tick();

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k]       = 1'b1;
                    wait_slots[k] = 0;
                    av[k]         = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
                    bv[k]         = N'($urandom);
                end else if (!pend[k]) begin
                    av[k] = N'($urandom);
                    bv[k] = N'($urandom);
                end
                bus.req_i[k]      = pend[k];
                bus.a_i[k*N +: N] = av[k];
                bus.b_i[k*N +: N] = bv[k];
            end
            bus.res_ready_i = ($urandom_range(0, 3) != 0);
            tick();
            if (last_w >= 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (pend[k] && k != last_w) wait_slots[k]++;
                end
                chk("fairness", 64'(wait_slots[last_w] < NR), 64'(1));
                pend[last_w]       = 1'b0;
                wait_slots[last_w] = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
